// File: rtl/sysid_chk_pkg.sv
// Shared types and constants for the system-ID boot checker:
// FSM states, error codes and the two sysid register addresses.
package sysid_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        GAP,
        CHECK,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ID      = 2'd1,
        ERR_TS      = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the
// sysid control_slave port (zero-latency slave).
interface sysid_boot_checker_if;

    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/avm_read_timer.sv
// Stall timer and per-word retry counter for the boot checker's read attempts.
// expire flags the stalled cycle that uses up the attempt; exhausted flags a spent retry budget.
module avm_read_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic stall,
    input  logic retry_inc,
    input  logic retry_clr,
    output logic expire,
    output logic exhausted
);

    localparam logic [15:0] LIMIT_M1  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    logic [15:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        timer_d = '0;
        retry_d = retry_q;
        // Any non-stalled cycle (accept, GAP, idle) restarts the attempt at zero.
        if (stall) begin
            timer_d = timer_q + 16'd1;
        end
        if (retry_clr) begin
            retry_d = '0;
        end else if (retry_inc) begin
            retry_d = retry_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    assign expire    = stall && (timer_q == LIMIT_M1);
    assign exhausted = (retry_q == RETRY_MAX);

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads the sysid ID and timestamp words over Avalon-MM,
// retries stalled reads, and reports pass/fail plus the captured values.
module sysid_boot_checker
    import sysid_chk_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1524785788,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    sysid_boot_checker_if.master        avm,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [1:0]                  err_code,
    output logic [31:0]                 id_value,
    output logic [31:0]                 ts_value
);

    state_e      state_q, state_d;
    err_e        err_q, err_d;
    logic        addr_q, addr_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        auto_q;

    logic rd_active, accept, stall, launch;
    logic retry_inc, retry_clr, expire, exhausted;

    assign rd_active = (state_q == RD_ID) || (state_q == RD_TS);
    assign accept    = rd_active && !avm.avm_waitrequest;
    assign stall     = rd_active &&  avm.avm_waitrequest;

    avm_read_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .stall     (stall),
        .retry_inc (retry_inc),
        .retry_clr (retry_clr),
        .expire    (expire),
        .exhausted (exhausted)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        addr_d    = addr_q;
        id_d      = id_q;
        ts_d      = ts_q;
        launch    = 1'b0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;

        unique case (state_q)
            IDLE: launch = start || auto_q;
            RD_ID: begin
                if (accept) begin
                    id_d      = avm.avm_readdata;
                    addr_d    = ADDR_TS;
                    retry_clr = 1'b1;
                    state_d   = RD_TS;
                end else if (expire) begin
                    retry_inc = 1'b1;
                    state_d   = GAP;
                end
            end
            RD_TS: begin
                if (accept) begin
                    ts_d      = avm.avm_readdata;
                    retry_clr = 1'b1;
                    state_d   = CHECK;
                end else if (expire) begin
                    retry_inc = 1'b1;
                    state_d   = GAP;
                end
            end
            // addr_q still names the word whose read timed out, so it picks the state to resume.
            GAP: begin
                if (exhausted) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = DONE;
                end else begin
                    state_d = (addr_q == ADDR_TS) ? RD_TS : RD_ID;
                end
            end
            CHECK: begin
                if (id_q != EXPECTED_ID) begin
                    err_d = ERR_ID;
                end else if (ts_q != EXPECTED_TS) begin
                    err_d = ERR_TS;
                end else begin
                    err_d = ERR_NONE;
                end
                state_d = DONE;
            end
            DONE: launch = start;
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d   = RD_ID;
            addr_d    = ADDR_ID;
            err_d     = ERR_NONE;
            retry_clr = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            err_q   <= ERR_NONE;
            addr_q  <= ADDR_ID;
            id_q    <= '0;
            ts_q    <= '0;
            auto_q  <= AUTO_START;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            auto_q  <= 1'b0;
        end
    end

    assign avm.avm_read    = rd_active;
    assign avm.avm_address = addr_q;

    assign busy     = rd_active || (state_q == GAP) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign pass     = done && (err_q == ERR_NONE);
    assign err_code = err_q;
    assign id_value = id_q;
    assign ts_value = ts_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker: a zero-latency sysid slave model with
// programmable read data and stall patterns, plus one task per scenario.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1524785788;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic        busy, done, pass;
    logic [1:0]  err_code;
    logic [31:0] id_value, ts_value;

    sysid_boot_checker_if avm ();

    // Slave model: address-1 reads stall while fewer than ts_stall_len cycles have
    // elapsed with address=1; stall_all stalls every read.
    logic [31:0] id_ret       = EXP_ID;
    logic [31:0] ts_ret       = EXP_TS;
    int          ts_stall_len = 0;
    bit          stall_all    = 1'b0;
    int          addr1_cnt    = 0;

    assign avm.avm_waitrequest = stall_all || (avm.avm_address && (addr1_cnt < ts_stall_len));
    assign avm.avm_readdata    = avm.avm_address ? ts_ret : id_ret;

    // Read activity monitors, sampled on the rising edge (pre-update values).
    logic read_prev   = 1'b0;
    int   read_rises  = 0;
    int   read_cycles = 0;

    always @(posedge clock) begin
        addr1_cnt <= avm.avm_address ? addr1_cnt + 1 : 0;
        read_prev <= avm.avm_read;
        if (avm.avm_read && !read_prev) read_rises <= read_rises + 1;
        if (avm.avm_read) read_cycles <= read_cycles + 1;
    end

    always #5 clock = ~clock;

    sysid_boot_checker dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .avm      (avm),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_code (err_code),
        .id_value (id_value),
        .ts_value (ts_value)
    );

    int checks = 0;
    int errors = 0;

    task automatic launch();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({busy, done, pass, err_code, avm.avm_read, avm.avm_address} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 0000000",
                     {busy, done, pass, err_code, avm.avm_read, avm.avm_address});
        end
        checks++;
        if ({id_value, ts_value} !== 64'd0) begin
            errors++;
            $display("FAIL reset_values: id=%h ts=%h, want 0", id_value, ts_value);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || avm.avm_read !== 1'b1 || avm.avm_address !== 1'b0) begin
            errors++;
            $display("FAIL auto_start: busy=%b read=%b addr=%b, want 1 1 0",
                     busy, avm.avm_read, avm.avm_address);
        end
        wait_done(20, "auto_done");
        checks++;
        if (pass !== 1'b1 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL auto_pass: pass=%b err=%0d, want 1 0", pass, err_code);
        end
    endtask

    task automatic test_basic_latency();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (avm.avm_read !== 1'b1 || avm.avm_address !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL lat_n1: read=%b addr=%b busy=%b done=%b, want 1 0 1 0",
                     avm.avm_read, avm.avm_address, busy, done);
        end
        @(negedge clock);
        checks++;
        if (avm.avm_read !== 1'b1 || avm.avm_address !== 1'b1) begin
            errors++;
            $display("FAIL lat_n2: read=%b addr=%b, want 1 1", avm.avm_read, avm.avm_address);
        end
        @(negedge clock);
        checks++;
        if (avm.avm_read !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL lat_n3: read=%b busy=%b done=%b, want 0 1 0", avm.avm_read, busy, done);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL lat_n4: done=%b busy=%b pass=%b err=%0d, want 1 0 1 0",
                     done, busy, pass, err_code);
        end
        checks++;
        if (id_value !== EXP_ID || ts_value !== EXP_TS) begin
            errors++;
            $display("FAIL lat_values: id=%h ts=%h, want %h %h", id_value, ts_value, EXP_ID, EXP_TS);
        end
    endtask

    task automatic test_compare(input logic [31:0] id_v, input logic [31:0] ts_v,
                                input logic [1:0] exp_err, input string name);
        int c0;
        id_ret = id_v;
        ts_ret = ts_v;
        c0 = read_cycles;
        launch();
        wait_done(20, name);
        checks++;
        if (err_code !== exp_err || pass !== (exp_err == 2'd0)) begin
            errors++;
            $display("FAIL %s_err: err=%0d pass=%b, want %0d %b", name, err_code, pass,
                     exp_err, (exp_err == 2'd0));
        end
        checks++;
        if (id_value !== id_v || ts_value !== ts_v || read_cycles - c0 !== 2) begin
            errors++;
            $display("FAIL %s_cap: id=%h ts=%h reads=%0d, want %h %h 2", name, id_value,
                     ts_value, read_cycles - c0, id_v, ts_v);
        end
        id_ret = EXP_ID;
        ts_ret = EXP_TS;
    endtask

    task automatic test_stall(input int stall_len, input int exp_rises, input int exp_cycles,
                              input string name);
        int r0, c0;
        ts_stall_len = stall_len;
        r0 = read_rises;
        c0 = read_cycles;
        launch();
        wait_done(1000, name);
        checks++;
        if (pass !== 1'b1 || err_code !== 2'd0 || ts_value !== EXP_TS) begin
            errors++;
            $display("FAIL %s_pass: pass=%b err=%0d ts=%h, want 1 0 %h", name, pass,
                     err_code, ts_value, EXP_TS);
        end
        checks++;
        if (read_rises - r0 !== exp_rises || read_cycles - c0 !== exp_cycles) begin
            errors++;
            $display("FAIL %s_shape: rises=%0d cycles=%0d, want %0d %0d", name,
                     read_rises - r0, read_cycles - c0, exp_rises, exp_cycles);
        end
        ts_stall_len = 0;
    endtask

    task automatic test_timeout();
        int r0, c0;
        id_ret = 32'h0000_00A5;
        launch();
        wait_done(20, "timeout_prep");
        id_ret    = EXP_ID;
        stall_all = 1'b1;
        r0 = read_rises;
        c0 = read_cycles;
        launch();
        wait_done(1000, "timeout");
        checks++;
        if (err_code !== 2'd3 || pass !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err=%0d pass=%b busy=%b, want 3 0 0", err_code, pass, busy);
        end
        checks++;
        if (read_rises - r0 !== 3 || read_cycles - c0 !== 765) begin
            errors++;
            $display("FAIL timeout_shape: rises=%0d cycles=%0d, want 3 765",
                     read_rises - r0, read_cycles - c0);
        end
        checks++;
        if (id_value !== 32'h0000_00A5 || ts_value !== EXP_TS) begin
            errors++;
            $display("FAIL timeout_keep: id=%h ts=%h, want 000000a5 %h", id_value, ts_value, EXP_TS);
        end
        stall_all = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int r0;
        ts_stall_len = 20;
        r0 = read_rises;
        launch();
        repeat (5) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(100, "busy_start");
        repeat (6) @(negedge clock);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || read_rises - r0 !== 1) begin
            errors++;
            $display("FAIL busy_start_ignored: done=%b busy=%b pass=%b rises=%0d, want 1 0 1 1",
                     done, busy, pass, read_rises - r0);
        end
        ts_stall_len = 0;
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (done !== (i % 4 == 0) || (done === 1'b1 && pass !== 1'b1)) begin
                errors++;
                $display("FAIL free_run_c%0d: done=%b pass=%b, want done=%b", i, done, pass,
                         (i % 4 == 0));
            end
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        ts_stall_len = 1000;
        launch();
        while (!(avm.avm_read && avm.avm_address) && n < 10) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (avm.avm_read !== 1'b1 || avm.avm_address !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_reach: read=%b addr=%b, want 1 1", avm.avm_read, avm.avm_address);
        end
        repeat (10) @(negedge clock);
        reset_n      = 1'b0;
        ts_stall_len = 0;
        #1;
        checks++;
        if ({busy, done, pass, err_code, avm.avm_read, avm.avm_address} !== 7'b0 ||
            {id_value, ts_value} !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: ctrl=%b id=%h ts=%h, want all 0",
                     {busy, done, pass, err_code, avm.avm_read, avm.avm_address}, id_value, ts_value);
        end
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(20, "rst_mid_rerun");
        checks++;
        if (pass !== 1'b1 || err_code !== 2'd0 || ts_value !== EXP_TS) begin
            errors++;
            $display("FAIL rst_mid_pass: pass=%b err=%0d ts=%h, want 1 0 %h", pass, err_code,
                     ts_value, EXP_TS);
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_compare(32'h0000_0001, EXP_TS, 2'd1, "id_mismatch");
        test_compare(EXP_ID, 32'h0000_0005, 2'd2, "ts_mismatch");
        test_compare(32'h0000_0007, 32'h0000_0009, 2'd1, "both_mismatch");
        test_stall(300, 2, 301, "stall_retry");
        test_stall(254, 1, 256, "accept_at_limit");
        test_timeout();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
